// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between a FIFO user (master) and the uart_rx_fifo (slave).
interface uart_rx_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              flush;
  logic              wr;
  logic [DWIDTH-1:0] wdata;
  logic              rd;
  logic [DWIDTH-1:0] rdata;
  logic              full;
  logic              mpty;
  logic [AW:0]       count;
  logic [1:0]        trig_lvl;
  logic              trig;
  logic              ovf;
  logic              udf;
  logic              err_clr;

  modport master (
    output flush, wr, wdata, rd, trig_lvl, err_clr,
    input  rdata, full, mpty, count, trig, ovf, udf
  );

  modport slave (
    input  flush, wr, wdata, rd, trig_lvl, err_clr,
    output rdata, full, mpty, count, trig, ovf, udf
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count, 16550-style trigger level,
// flush and sticky overflow/underflow flags.
module uart_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] TH_ONE  = (AW+1)'(1);
  localparam logic [AW:0] TH_QTR  = (AW+1)'(DEPTH / 4);
  localparam logic [AW:0] TH_HALF = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] TH_NEAR = (AW+1)'(DEPTH - 2);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              ovf_q;
  logic              udf_q;
  logic              full;
  logic              mpty;
  logic              wr_ok;
  logic              rd_ok;
  logic [AW:0]       thresh;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mpty  = (wr_ptr == rd_ptr);
  assign wr_ok = bus.wr && (!full || bus.rd);
  assign rd_ok = bus.rd && !mpty;

  assign bus.full  = full;
  assign bus.mpty  = mpty;
  assign bus.count = wr_ptr - rd_ptr;
  assign bus.rdata = mem[rd_ptr[AW-1:0]];
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    thresh = TH_ONE;
    case (bus.trig_lvl)
      2'b00:   thresh = TH_ONE;
      2'b01:   thresh = TH_QTR;
      2'b10:   thresh = TH_HALF;
      default: thresh = TH_NEAR;
    endcase
  end

  assign bus.trig = (bus.count >= thresh);

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so resetting the array would only cost flops. A stray
  // write during rst or flush is harmless because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= bus.wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sticky error flags: a new event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr && full && !bus.rd) ovf_q <= 1'b1;
      else if (bus.err_clr)          ovf_q <= 1'b0;

      if (bus.rd && mpty)            udf_q <= 1'b1;
      else if (bus.err_clr)          udf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table plus
// hand-written sequences for fill/drain, boundaries, overflow, trigger/flush
// and a scoreboarded interleaved run.
module tb_uart_rx_fifo;
  localparam int DWIDTH = 8;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  uart_rx_fifo_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       wr;
    logic       rd;
    logic       err_clr;
    logic [1:0] lvl;
    logic [7:0] wdata;
    int         e_count;
    logic       e_trig;
    logic       e_ovf;
    logic       e_udf;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush   = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr    = 1'b1;
    bus.wdata = d;
    step();
    bus.wr    = 1'b0;
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  logic [7:0] sb [$];

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle();
    bus.wdata    = '0;
    bus.trig_lvl = 2'b00;

    // Reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mpty",  32'(bus.mpty),  32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_udf",   32'(bus.udf),   32'd0);
    check("rst_trig",  32'(bus.trig),  32'd0);

    // Directed table: flush wr rd clr lvl wdata | count trig ovf udf rdata
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h11, 1, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h22, 2, 1'b1, 1'b0, 1'b0, 8'h11};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h22};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h33, 1, 1'b1, 1'b0, 1'b0, 8'h33};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h44, 1, 1'b0, 1'b0, 1'b0, 8'h44};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 9; i++) begin
      bus.flush    = vecs[i].flush;
      bus.wr       = vecs[i].wr;
      bus.rd       = vecs[i].rd;
      bus.err_clr  = vecs[i].err_clr;
      bus.trig_lvl = vecs[i].lvl;
      bus.wdata    = vecs[i].wdata;
      step();
      check($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_mpty", i),  32'(bus.mpty),  32'(vecs[i].e_count == 0));
      check($sformatf("v%0d_trig", i),  32'(bus.trig),  32'(vecs[i].e_trig));
      check($sformatf("v%0d_ovf", i),   32'(bus.ovf),   32'(vecs[i].e_ovf));
      check($sformatf("v%0d_udf", i),   32'(bus.udf),   32'(vecs[i].e_udf));
      if (vecs[i].e_count != 0)
        check($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].e_rdata));
    end
    idle();
    bus.trig_lvl = 2'b00;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_rdata%0d", i), 32'(bus.rdata), 32'(i));
      pop();
    end
    check("drain_mpty", 32'(bus.mpty), 32'd1);

    // Full boundary: simultaneous rd and wr
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
    bus.wr = 1'b1; bus.rd = 1'b1; bus.wdata = 8'hEE;
    step();
    idle();
    check("fullrw_count", 32'(bus.count), 32'd16);
    check("fullrw_head",  32'(bus.rdata), 32'h81);
    check("fullrw_ovf",   32'(bus.ovf),   32'd0);

    // Empty boundary: simultaneous rd and wr
    do_flush();
    bus.wr = 1'b1; bus.rd = 1'b1; bus.wdata = 8'hA5;
    step();
    idle();
    check("emptyrw_count", 32'(bus.count), 32'd1);
    check("emptyrw_udf",   32'(bus.udf),   32'd1);
    check("emptyrw_rdata", 32'(bus.rdata), 32'hA5);
    bus.err_clr = 1'b1;
    step();
    idle();
    check("udf_clr", 32'(bus.udf), 32'd0);

    // Overflow
    do_flush();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    push(8'h5A);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_set",   32'(bus.ovf),   32'd1);
    bus.err_clr = 1'b1; bus.wr = 1'b1; bus.wdata = 8'h5B;
    step();
    idle();
    check("ovf_set_wins", 32'(bus.ovf), 32'd1);
    bus.err_clr = 1'b1;
    step();
    idle();
    check("ovf_clr", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_rdata%0d", i), 32'(bus.rdata), 32'(i));
      pop();
    end
    check("ovf_drained", 32'(bus.mpty), 32'd1);

    // Trigger and flush
    bus.trig_lvl = 2'b10;
    for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
    check("trig_7", 32'(bus.trig), 32'd0);
    push(8'h67);
    check("trig_8", 32'(bus.trig), 32'd1);
    bus.trig_lvl = 2'b11;
    #1;
    check("trig_lvl3_at8", 32'(bus.trig), 32'd0);
    bus.trig_lvl = 2'b10;
    bus.flush = 1'b1; bus.wr = 1'b1; bus.wdata = 8'h77;
    step();
    idle();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_mpty",  32'(bus.mpty),  32'd1);
    step();
    check("flush_wr_dropped", 32'(bus.count), 32'd0);
    bus.trig_lvl = 2'b00;

    // Interleaved run against a scoreboard, wrapping the pointers
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      logic       w;
      logic       r;
      logic [7:0] d;
      w = ($urandom_range(0, 99) < (sb.size() < 8 ? 75 : 40));
      r = ($urandom_range(0, 99) < (sb.size() < 8 ? 35 : 70));
      d = 8'($urandom);
      if (r && sb.size() > 0)
        check($sformatf("mix_rdata%0d", i), 32'(bus.rdata), 32'(sb[0]));
      bus.wr = w; bus.rd = r; bus.wdata = d;
      step();
      idle();
      if (r && sb.size() > 0) void'(sb.pop_front());
      if (w && (sb.size() < DEPTH || r)) sb.push_back(d);
      check($sformatf("mix_count%0d", i), 32'(bus.count), 32'(sb.size()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
